chi_engine: RTL and testbench
=============================

# chi_engine

Sequential, parametrised Keccak χ (Chi) step engine for the SHA-3 datapath. Accepts a full 25-lane Keccak state over a valid/ready handshake, applies χ row by row (optionally fused with ι), and returns the result over a second valid/ready handshake. It sits between the π stage and the round-state register and generalises the fixed 64-bit combinational χ to all Keccak-f widths with selectable area/latency.

## Interface
- LANE_W, 64, lane width in bits; legal values are 8, 16, 32 and 64 (Keccak-f[200/400/800/1600]).
- ROWS_PER_CYCLE, 1, number of χ rows computed per cycle; legal values are 1 and 5. Elaboration fails on any other value.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input state offered.
- in_ready  out  1  engine can accept a state.
- in_state  in  25*LANE_W  lane i = x+5y at bits [i*LANE_W +: LANE_W].
- in_rc  in  LANE_W  round constant; present only when KECCAK_IOTA_EN is defined.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_state  out  25*LANE_W  result state, same lane packing as the input.
- busy  out  1  high in CALC and DONE.

## Operation
- Row y comprises lanes 5y..5y+4. χ is a[x] ^= (~a[x+1 mod 5]) & a[x+2 mod 5]. All reads within a row use pre-χ values of that row.
- The FSM has three states: IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_state (and in_rc) into the state register, clear row_cnt to 0, go to CALC.
- CALC:
  - Each cycle, rows row_cnt .. row_cnt+ROWS_PER_CYCLE-1 are transformed in place and row_cnt += ROWS_PER_CYCLE.
  - When the last row (row 4) is written, go to DONE.
  - row_cnt is 3 bits and never exceeds 5.
- DONE:
  - out_valid=1 and out_state is driven from the state register.
  - On out_valid&out_ready, go to IDLE.
- in_ready is 0 in CALC and DONE. There is no overlap of a new input with a pending output.
- in_state and in_rc are sampled only at the accept edge. Later changes on these inputs are ignored.
- There is no arithmetic beyond bitwise operations; widths are exact and no truncation occurs.

## Timing
- Reset values:
  - State is IDLE; row_cnt=0; state register=0.
  - out_valid=0, out_state=0, busy=0.
  - in_ready=0 while rst is asserted and 1 from the first cycle after deassertion.
- Latency from the accept edge to out_valid high:
  - ROWS_PER_CYCLE=5: 2 cycles.
  - ROWS_PER_CYCLE=1: 6 cycles.
- Throughput is one state per (latency+1) cycles when out_ready is held high.
- Backpressure:
  - out_state and out_valid stay stable while out_ready=0.
  - in_ready stays 0 for the whole hold time.
- in_ready rises in the cycle after the output handshake.
- Reset asserted mid-CALC or mid-DONE: the engine enters IDLE asynchronously and the partial result is discarded. out_valid drops immediately.

## Configuration
- KECCAK_IOTA_EN defined:
  - The in_rc port exists and is registered at accept.
  - On the cycle row 0 is transformed, lane 0 becomes χ(lane 0) ^ rc.
  - The engine then performs χ∘ι for one round.
- KECCAK_IOTA_EN undefined:
  - There is no in_rc port and no rc register.
  - Output is pure χ.

## Structure
- keccak_pkg contains:
  - NUM_LANES=25 and NUM_ROWS=5.
  - The chi_state_t enum (IDLE, CALC, DONE).
  - A lane-slice function lane(state, idx, width).
- Sub-module chi_row: combinational 5-lane χ transform of one row, parametrised by LANE_W. chi_engine instantiates ROWS_PER_CYCLE copies and muxes them by row_cnt.

## Test plan
- All-zero in_state, LANE_W=64, ROWS_PER_CYCLE=1 -> out_valid 6 cycles after accept; out_state all zero.
- Lane 1 = 64'hFFFF_FFFF_FFFF_FFFF, all other lanes 0 -> out lanes 1 and 4 = all ones; all other lanes 0.
- All-ones state, LANE_W=8, ROWS_PER_CYCLE=5 -> out_state all ones; out_valid 2 cycles after accept.
- KECCAK_IOTA_EN, all-zero state, in_rc=64'h0000_0000_0000_8082 -> lane 0 = 64'h8082; all other lanes 0.
- out_ready held low 3 cycles in DONE -> out_state stable, in_ready=0 throughout; handshake on cycle 4, then in_ready=1 next cycle.
- rst pulsed during CALC (row_cnt=2) -> out_valid never rises; IDLE with in_ready=1 the cycle after release; the next state processes correctly.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared constants, FSM state type and a lane-extraction helper for the Keccak chi engine.
package keccak_pkg;

  localparam int NUM_LANES  = 25;
  localparam int NUM_ROWS   = 5;
  localparam int ROW_LANES  = NUM_LANES / NUM_ROWS;
  localparam int MAX_LANE_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } chi_state_t;

  // Lane idx of a state packed at a lane width of 'width' bits, zero-extended to 64 bits.
  function automatic logic [MAX_LANE_W-1:0] lane(
    input logic [NUM_LANES*MAX_LANE_W-1:0] state,
    input int                              idx,
    input int                              width
  );
    logic [NUM_LANES*MAX_LANE_W-1:0] w_shift;
    logic [MAX_LANE_W-1:0]           w_mask;
    w_shift = state >> (idx * width);
    w_mask  = (width >= MAX_LANE_W) ? {MAX_LANE_W{1'b1}} : ((64'd1 << width) - 64'd1);
    return w_shift[MAX_LANE_W-1:0] & w_mask;
  endfunction

endpackage

// File: rtl/chi_row.sv
// Combinational chi transform of one five-lane Keccak row; all reads use the pre-chi row.
module chi_row
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic [ROW_LANES*LANE_W-1:0] i_row,
  output logic [ROW_LANES*LANE_W-1:0] o_row
);

  for (genvar x = 0; x < ROW_LANES; x++) begin : g_lane
    assign o_row[x*LANE_W +: LANE_W] =
        i_row[x*LANE_W +: LANE_W] ^
        (~i_row[((x + 1) % ROW_LANES)*LANE_W +: LANE_W] &
          i_row[((x + 2) % ROW_LANES)*LANE_W +: LANE_W]);
  end

endmodule

// File: rtl/chi_engine.sv
// Sequential Keccak chi engine: accepts a 25-lane state, applies chi ROWS_PER_CYCLE rows per cycle.
// Define KECCAK_IOTA_EN to add the in_rc port and fuse iota into the row-0 update.
module chi_engine
  import keccak_pkg::*;
#(
  parameter int LANE_W         = 64,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [NUM_LANES*LANE_W-1:0] i_in_state,
`ifdef KECCAK_IOTA_EN
  input  logic [LANE_W-1:0]           i_in_rc,
`endif
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [NUM_LANES*LANE_W-1:0] o_out_state,
  output logic                        o_busy
);

  localparam int              STATE_W = NUM_LANES * LANE_W;
  localparam int              ROW_W   = ROW_LANES * LANE_W;
  localparam logic [2:0]      STEP    = 3'(ROWS_PER_CYCLE);

  if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 5)) begin : g_bad_rows
    $error("chi_engine: ROWS_PER_CYCLE must be 1 or 5");
  end
  if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane
    $error("chi_engine: LANE_W must be 8, 16, 32 or 64");
  end

  chi_state_t         r_fsm;
  chi_state_t         w_fsm_nxt;
  logic [2:0]         r_row_cnt;
  logic [2:0]         w_cnt_step;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic               w_accept;
  logic [2:0]         w_idx     [ROWS_PER_CYCLE];
  logic [ROW_W-1:0]   w_row_in  [ROWS_PER_CYCLE];
  logic [ROW_W-1:0]   w_row_chi [ROWS_PER_CYCLE];
  logic [ROW_W-1:0]   w_row_new [ROWS_PER_CYCLE];
`ifdef KECCAK_IOTA_EN
  logic [LANE_W-1:0]  r_rc;
`endif

  assign w_accept   = i_in_valid & r_in_ready;
  assign w_cnt_step = r_row_cnt + STEP;

  // Row slots g select rows row_cnt+g; out-of-range indices (outside CALC) fold to row 0.
  for (genvar g = 0; g < ROWS_PER_CYCLE; g++) begin : g_row
    logic [2:0] w_sum;
    assign w_sum       = r_row_cnt + 3'(g);
    assign w_idx[g]    = (w_sum < 3'(NUM_ROWS)) ? w_sum : 3'd0;
    assign w_row_in[g] = r_state[int'(w_idx[g])*ROW_W +: ROW_W];

    chi_row #(.LANE_W(LANE_W)) u_chi_row (
      .i_row (w_row_in[g]),
      .o_row (w_row_chi[g])
    );

`ifdef KECCAK_IOTA_EN
    assign w_row_new[g] = (w_idx[g] == 3'd0)
                        ? (w_row_chi[g] ^ {{(ROW_W-LANE_W){1'b0}}, r_rc})
                        : w_row_chi[g];
`else
    assign w_row_new[g] = w_row_chi[g];
`endif
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    w_fsm_nxt = w_accept ? CALC : IDLE;
      CALC:    w_fsm_nxt = (w_cnt_step == 3'(NUM_ROWS)) ? DONE : CALC;
      DONE:    w_fsm_nxt = i_out_ready ? IDLE : DONE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_fsm)
      IDLE: begin
        if (w_accept) w_state_nxt = i_in_state;
        else          w_state_nxt = r_state;
      end
      CALC: begin
        for (int g = 0; g < ROWS_PER_CYCLE; g++) begin
          w_state_nxt[int'(w_idx[g])*ROW_W +: ROW_W] = w_row_new[g];
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_fsm <= IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= '0;
      r_row_cnt <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_fsm == IDLE && w_accept) r_row_cnt <= 3'd0;
      else if (r_fsm == CALC)        r_row_cnt <= w_cnt_step;
    end
  end

`ifdef KECCAK_IOTA_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                          r_rc <= '0;
    else if (r_fsm == IDLE && w_accept) r_rc <= i_in_rc;
  end
`endif

  // Handshake flags follow the next FSM state so they line up with the state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_fsm_nxt == IDLE);
      r_out_valid <= (w_fsm_nxt == DONE);
      r_busy      <= (w_fsm_nxt != IDLE);
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_out_state = r_state;

endmodule

// File: tb/tb_chi_engine.sv
// Directed bench for chi_engine: a 64-bit/1-row instance and an 8-bit/5-row instance.
module tb_chi_engine;
  import keccak_pkg::*;

  localparam int W   = 64;
  localparam int SW  = 25 * W;
  localparam int W8  = 8;
  localparam int SW8 = 25 * W8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, out_ready, in_ready, out_valid, busy;
  logic [SW-1:0]  in_state, out_state;
  logic           in_valid_8, out_ready_8, in_ready_8, out_valid_8, busy_8;
  logic [SW8-1:0] in_state_8, out_state_8;
`ifdef KECCAK_IOTA_EN
  logic [W-1:0]   in_rc;
  logic [W8-1:0]  in_rc_8;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  chi_engine #(.LANE_W(W), .ROWS_PER_CYCLE(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_state(in_state),
`ifdef KECCAK_IOTA_EN
    .i_in_rc(in_rc),
`endif
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_state(out_state), .o_busy(busy)
  );

  chi_engine #(.LANE_W(W8), .ROWS_PER_CYCLE(5)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid_8), .o_in_ready(in_ready_8),
    .i_in_state(in_state_8),
`ifdef KECCAK_IOTA_EN
    .i_in_rc(in_rc_8),
`endif
    .o_out_valid(out_valid_8), .i_out_ready(out_ready_8), .o_out_state(out_state_8), .o_busy(busy_8)
  );

  typedef struct {
    string         name;
    logic [SW-1:0] st;
    logic [W-1:0]  rc;
    logic [SW-1:0] exp;
  } vec_t;

  function automatic logic [SW-1:0] sl(input logic [SW-1:0] s, input int idx, input logic [W-1:0] v);
    s[idx*W +: W] = v;
    return s;
  endfunction

  function automatic logic [SW8-1:0] sl8(input logic [SW8-1:0] s, input int idx, input logic [W8-1:0] v);
    s[idx*W8 +: W8] = v;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic chk_state(input string nm, input logic [SW-1:0] got, input logic [SW-1:0] exp, input int width);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      for (int i = 0; i < 25; i++) begin
        if (lane(got, i, width) !== lane(exp, i, width)) begin
          $display("FAIL %s: lane %0d got=%h expected=%h", nm, i, lane(got, i, width), lane(exp, i, width));
          break;
        end
      end
    end
  endtask

  // Offer st, wait for the accept edge, scramble inputs, then count cycles until out_valid.
  task automatic txn64(input logic [SW-1:0] st, output int lat, output logic bsy);
    int i;
    @(negedge clk);
    in_state = st;
    in_valid = 1'b1;
    i = 0;
    while (!in_ready && i < 20) begin @(negedge clk); i++; end
    if (!in_ready) begin
      n_checks++; n_errors++;
      $display("FAIL accept64: in_ready stuck low got=0 expected=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = {50{$urandom}};
`ifdef KECCAK_IOTA_EN
    in_rc = {$urandom, $urandom};
`endif
    bsy = busy;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic txn8(input logic [SW8-1:0] st, output int lat);
    int i;
    @(negedge clk);
    in_state_8 = st;
    in_valid_8 = 1'b1;
    i = 0;
    while (!in_ready_8 && i < 20) begin @(negedge clk); i++; end
    @(posedge clk); #1;
    in_valid_8 = 1'b0;
    in_state_8 = {7{$urandom}};
    lat = 1;
    while (!out_valid_8 && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  vec_t           vecs[7];
  logic [SW-1:0]  z;
  logic [W-1:0]   ka, kb, kx;
  logic [SW8-1:0] z8;
  logic [SW8-1:0] st8   [3];
  logic [SW8-1:0] exp8  [3];
  int             lat;
  int             rises;
  logic           bsy;

  initial begin
    z  = '0;
    z8 = '0;
    ka = 64'hFF00_FF00_FF00_FF00;
    kb = 64'h0F0F_0F0F_0F0F_0F0F;
    kx = 64'hDEAD_BEEF_0123_4567;

    vecs[0] = '{"zero",   z,                 64'h0, z};
    vecs[1] = '{"lane1",  sl(z, 1, '1),      64'h0, sl(sl(z, 1, '1), 4, '1)};
    vecs[2] = '{"ones",   '1,                64'h0, '1};
    vecs[3] = '{"lane2",  sl(z, 2, 64'hF0F0_F0F0_F0F0_F0F0), 64'h0,
                sl(sl(z, 0, 64'hF0F0_F0F0_F0F0_F0F0), 2, 64'hF0F0_F0F0_F0F0_F0F0)};
    vecs[4] = '{"row4",   sl(sl(z, 21, ka), 22, kb), 64'h0,
                sl(sl(sl(sl(z, 20, 64'h000F_000F_000F_000F), 21, ka), 22, kb), 24, ka)};
    vecs[5] = '{"multi",  sl(sl(sl(sl(z, 1, '1), 10, kx), 21, ka), 22, kb), 64'h0,
                sl(sl(sl(sl(sl(sl(sl(sl(z, 1, '1), 4, '1), 10, kx), 13, kx),
                   20, 64'h000F_000F_000F_000F), 21, ka), 22, kb), 24, ka)};
`ifdef KECCAK_IOTA_EN
    vecs[6] = '{"iota",   z, 64'h0000_0000_0000_8082, sl(z, 0, 64'h0000_0000_0000_8082)};
`else
    vecs[6] = '{"iota",   z, 64'h0000_0000_0000_8082, z};
`endif

    st8[0]  = '1;                  exp8[0] = '1;
    st8[1]  = sl8(z8, 1, 8'hFF);   exp8[1] = sl8(sl8(z8, 1, 8'hFF), 4, 8'hFF);
    st8[2]  = sl8(z8, 2, 8'hA5);   exp8[2] = sl8(sl8(z8, 0, 8'hA5), 2, 8'hA5);

    rst = 1'b1;
    in_valid = 1'b0;   in_state = '0;   out_ready = 1'b1;
    in_valid_8 = 1'b0; in_state_8 = '0; out_ready_8 = 1'b1;
`ifdef KECCAK_IOTA_EN
    in_rc = '0; in_rc_8 = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk_state("rst_out_state", out_state, z, W);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    for (int v = 0; v < 7; v++) begin
`ifdef KECCAK_IOTA_EN
      in_rc = vecs[v].rc;
`endif
      txn64(vecs[v].st, lat, bsy);
      chk({vecs[v].name, "_lat"}, 64'(lat), 64'd6);
      chk_state({vecs[v].name, "_out"}, out_state, vecs[v].exp, W);
      if (v == 0) chk("busy_calc", 64'(bsy), 64'd1);
      @(posedge clk); #1;
      chk({vecs[v].name, "_ready_after"}, 64'(in_ready), 64'd1);
    end

    for (int v = 0; v < 3; v++) begin
      txn8(st8[v], lat);
      chk($sformatf("w8_%0d_lat", v), 64'(lat), 64'd2);
      chk_state($sformatf("w8_%0d_out", v), SW'(out_state_8), SW'(exp8[v]), W8);
    end

    // Backpressure: hold out_ready low for three DONE cycles.
    out_ready = 1'b0;
    txn64(vecs[3].st, lat, bsy);
    chk("bp_lat", 64'(lat), 64'd6);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp_in_ready_%0d", k), 64'(in_ready), 64'd0);
      chk_state($sformatf("bp_state_%0d", k), out_state, vecs[3].exp, W);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after", 64'(in_ready), 64'd1);
    chk("bp_valid_after", 64'(out_valid), 64'd0);

    // Reset while row_cnt is 2, then check recovery.
    @(negedge clk);
    in_state = vecs[1].st;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk_state("mid_rst_state", out_state, z, W);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rel_ready", 64'(in_ready), 64'd1);
    rises = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) rises++;
      @(posedge clk); #1;
    end
    chk("mid_no_valid", 64'(rises), 64'd0);
`ifdef KECCAK_IOTA_EN
    in_rc = '0;
`endif
    txn64(vecs[4].st, lat, bsy);
    chk("mid_next_lat", 64'(lat), 64'd6);
    chk_state("mid_next_out", out_state, vecs[4].exp, W);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
